// File: rtl/bcd_pkg.sv
// Shared types and constants for the decimal datapath.
// Digit encoding, FSM states and a BCD validity helper.
package bcd_pkg;

  localparam int         BCD_W    = 4;
  localparam logic [3:0] BCD_NINE = 4'd9;
  localparam logic [4:0] BCD_TEN  = 5'd10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  typedef logic [BCD_W-1:0] bcd_digit_t;

  function automatic logic is_bcd(bcd_digit_t d);
    return d <= BCD_NINE;
  endfunction

endpackage

// File: rtl/bcd_digit_sub.sv
// One BCD digit of a - b - bin via nine's-complement addition.
// Majority-gate ripple adder, then a decimal correction stage.
module bcd_digit_sub
  import bcd_pkg::*;
(
  input  bcd_digit_t a,
  input  bcd_digit_t b,
  input  logic       bin,
  output bcd_digit_t d,
  output logic       bout
);

  function automatic logic maj(logic x, logic y, logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  bcd_digit_t nb;
  logic [4:0] c;
  logic [4:0] t;
  logic [4:0] tm;

  assign nb   = BCD_NINE - b;
  assign c[0] = ~bin;

  for (genvar k = 0; k < BCD_W; k++) begin : g_fa
    assign t[k]   = a[k] ^ nb[k] ^ c[k];
    assign c[k+1] = maj(a[k], nb[k], c[k]);
  end

  assign t[4] = c[4];

  // A sum above nine means the digit did not need to borrow.
  assign bout = (t <= 5'd9);
  assign tm   = t - BCD_TEN;
  assign d    = bout ? t[3:0] : tm[3:0];

endmodule

// File: rtl/bcd_serial_sub.sv
// Digit-serial BCD subtractor, LSD first, with optional
// sign-magnitude correction of negative results.
module bcd_serial_sub
  import bcd_pkg::*;
#(
  parameter int NDIG = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              mag,
  input  logic [4*NDIG-1:0] dA,
  input  logic [4*NDIG-1:0] dB,
  input  logic              bin,
  output logic              ready,
  output logic              done,
  output logic [4*NDIG-1:0] dD,
  output logic              dbout,
  output logic              neg,
  output logic              err
);

  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [IW-1:0] LAST = IW'(NDIG - 1);

  state_t st, st_n;

  bcd_digit_t [NDIG-1:0] ain, bin_d;
  bcd_digit_t [NDIG-1:0] ra, ra_n;
  bcd_digit_t [NDIG-1:0] rb, rb_n;
  bcd_digit_t [NDIG-1:0] dq, dq_n;

  logic [IW-1:0] idx, idx_n;
  logic          mg, mg_n;
  logic          brw, brw_n;
  logic          dbout_n, neg_n, err_n;
  logic          bad;

  bcd_digit_t dig_a, dig_b, dig_d;
  logic       dig_bout;

  assign ain   = dA;
  assign bin_d = dB;

  always_comb begin
    bad = 1'b0;
    for (int k = 0; k < NDIG; k++) begin
      if (!is_bcd(ain[k]) || !is_bcd(bin_d[k])) bad = 1'b1;
    end
  end

  // FIX negates the raw digits in place: 0 - D[i] - borrow.
  assign dig_a = (st == FIX) ? '0 : ra[idx];
  assign dig_b = (st == FIX) ? dq[idx] : rb[idx];

  bcd_digit_sub u_dig (
    .a    (dig_a),
    .b    (dig_b),
    .bin  (brw),
    .d    (dig_d),
    .bout (dig_bout)
  );

  always_comb begin
    st_n    = st;
    ra_n    = ra;
    rb_n    = rb;
    dq_n    = dq;
    idx_n   = idx;
    mg_n    = mg;
    brw_n   = brw;
    dbout_n = dbout;
    neg_n   = neg;
    err_n   = err;
    unique case (st)
      IDLE: begin
        if (start) begin
          ra_n  = ain;
          rb_n  = bin_d;
          mg_n  = mag;
          idx_n = '0;
          err_n = 1'b0;
          if (bad) begin
            err_n   = 1'b1;
            dq_n    = '0;
            dbout_n = 1'b0;
            neg_n   = 1'b0;
            st_n    = DONE;
          end else begin
            brw_n = bin;
            st_n  = SUB;
          end
        end
      end
      SUB: begin
        dq_n[idx] = dig_d;
        brw_n     = dig_bout;
        idx_n     = idx + 1'b1;
        if (idx == LAST) begin
          dbout_n = dig_bout;
          neg_n   = dig_bout;
          idx_n   = '0;
          if (dig_bout && mg) begin
            brw_n = 1'b0;
            st_n  = FIX;
          end else begin
            st_n = DONE;
          end
        end
      end
      FIX: begin
        dq_n[idx] = dig_d;
        brw_n     = dig_bout;
        idx_n     = idx + 1'b1;
        if (idx == LAST) st_n = DONE;
      end
      DONE: st_n = IDLE;
      default: st_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      st    <= IDLE;
      ra    <= '0;
      rb    <= '0;
      dq    <= '0;
      idx   <= '0;
      mg    <= 1'b0;
      brw   <= 1'b0;
      dbout <= 1'b0;
      neg   <= 1'b0;
      err   <= 1'b0;
    end else begin
      st    <= st_n;
      ra    <= ra_n;
      rb    <= rb_n;
      dq    <= dq_n;
      idx   <= idx_n;
      mg    <= mg_n;
      brw   <= brw_n;
      dbout <= dbout_n;
      neg   <= neg_n;
      err   <= err_n;
    end
  end

  assign ready = (st == IDLE);
  assign done  = (st == DONE);
  assign dD    = dq;

endmodule

// File: tb/tb_bcd_serial_sub.sv
// Directed bench for bcd_serial_sub with NDIG=4.
// Latency is counted in edges from accept to the edge sampling done.
module tb_bcd_serial_sub;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        mag;
  logic [15:0] dA, dB;
  logic        bin;
  logic        ready, done, dbout, neg, err;
  logic [15:0] dD;

  int checks   = 0;
  int failures = 0;

  bcd_serial_sub #(.NDIG(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .mag   (mag),
    .dA    (dA),
    .dB    (dB),
    .bin   (bin),
    .ready (ready),
    .done  (done),
    .dD    (dD),
    .dbout (dbout),
    .neg   (neg),
    .err   (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic op(input logic [15:0] a, input logic [15:0] b,
                    input logic bi, input logic m, output int lat);
    int k;
    @(negedge clk);
    dA = a; dB = b; bin = bi; mag = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (!done && k < 40) begin
      @(posedge clk); #1;
      k++;
    end
    lat = k + 1;
  endtask

  task automatic run(input string tag, input logic [15:0] a,
                     input logic [15:0] b, input logic bi,
                     input logic m, input logic [15:0] ed,
                     input logic en, input logic ee, input int el);
    int lat;
    op(a, b, bi, m, lat);
    chk({tag, "_lat"}, lat, el);
    chk({tag, "_dD"}, dD, ed);
    chk({tag, "_dbout"}, dbout, en);
    chk({tag, "_neg"}, neg, en);
    chk({tag, "_err"}, err, ee);
    @(posedge clk); #1;
    chk({tag, "_done_pulse"}, done, 1'b0);
    chk({tag, "_ready"}, ready, 1'b1);
  endtask

  initial begin
    int nd;
    int last;
    int lat;
    rst_n = 1'b0; start = 1'b0; mag = 1'b0;
    dA = '0; dB = '0; bin = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", ready, 1'b1);
    chk("rst_done", done, 1'b0);
    chk("rst_dD", dD, 16'h0000);
    chk("rst_flags", {dbout, neg, err}, 3'b000);
    @(negedge clk) rst_n = 1'b1;

    run("basic", 16'h0042, 16'h0017, 1'b0, 1'b0, 16'h0025, 1'b0, 1'b0, 5);
    run("neg_raw", 16'h0000, 16'h0001, 1'b0, 1'b0, 16'h9999, 1'b1, 1'b0, 5);
    run("neg_mag", 16'h0000, 16'h0001, 1'b0, 1'b1, 16'h0001, 1'b1, 1'b0, 9);
    run("eq_bin1", 16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0, 9);
    run("eq_bin0", 16'h1234, 16'h1234, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0, 5);
    run("neg_tc", 16'h0100, 16'h0358, 1'b0, 1'b0, 16'h9742, 1'b1, 1'b0, 5);
    run("neg_tcm", 16'h0100, 16'h0358, 1'b0, 1'b1, 16'h0258, 1'b1, 1'b0, 9);
    run("carry", 16'h5000, 16'h0001, 1'b1, 1'b0, 16'h4998, 1'b0, 1'b0, 5);
    run("bad_dig", 16'h00A0, 16'h0003, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 1);
    run("err_clr", 16'h0042, 16'h0017, 1'b0, 1'b0, 16'h0025, 1'b0, 1'b0, 5);

    // busy start is ignored
    @(negedge clk);
    dA = 16'h0042; dB = 16'h0017; bin = 1'b0; mag = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    nd = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    dA = 16'h1111; dB = 16'h0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (14) begin
      if (done) nd++;
      @(posedge clk); #1;
    end
    chk("busy_ndone", nd, 1);
    chk("busy_dD", dD, 16'h0025);

    // back-to-back with start held
    @(negedge clk);
    dA = 16'h9999; dB = 16'h0000; bin = 1'b0; mag = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    nd = 0;
    last = -1;
    for (int k = 0; k < 30; k++) begin
      if (done) begin
        chk("b2b_dD", dD, 16'h9999);
        if (last >= 0) chk("b2b_gap", k - last, 6);
        last = k;
        nd++;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    chk("b2b_ndone", nd, 5);
    nd = 0;
    while (!ready && nd < 20) begin
      @(posedge clk); #1;
      nd++;
    end
    chk("b2b_idle", ready, 1'b1);

    // reset mid-SUB
    run("pre_rst", 16'h0000, 16'h0001, 1'b0, 1'b0, 16'h9999, 1'b1, 1'b0, 5);
    @(negedge clk);
    dA = 16'h0042; dB = 16'h0017; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("mid_busy", ready, 1'b0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mrst_ready", ready, 1'b1);
    chk("mrst_dD", dD, 16'h0000);
    chk("mrst_flags", {dbout, neg, err}, 3'b000);
    nd = 0;
    repeat (10) begin
      if (done) nd++;
      @(posedge clk); #1;
    end
    chk("mrst_nodone", nd, 0);

    run("post_rst", 16'h9000, 16'h0999, 1'b0, 1'b1, 16'h8001, 1'b0, 1'b0, 5);
    lat = 0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
